rv32zhinx_issue_ctrl: RTL and testbench
=======================================

RV32ZHINX_ISSUE_CTRL -- requirements
Module: rv32zhinx_issue_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 16, WAIT-state cycles before abort; honoured only when RV32ZHINX_ISSUE_TIMEOUT_EN is defined.
REQ-002 SHALL have port: CLK  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: nRST  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: req_valid in 1 core request strobe; req_ready out 1 controller can accept.
REQ-005 SHALL have ports: req_op in fpu_operation_t; req_a in WORD_W; req_b in WORD_W; req_rd in 5 (destination register tag).
REQ-006 SHALL have ports: rv32zhinx_start out 1; operation out fpu_operation_t; rv32zhinx_a out WORD_W; rv32zhinx_b out WORD_W (drive FPU unit).
REQ-007 SHALL have ports: rv32zhinx_done in 1; rv32zhinx_out in WORD_W (FPU response, may be combinational from start).
REQ-008 SHALL have ports: resp_valid out 1; resp_ready in 1; resp_data out WORD_W; resp_rd out 5; resp_err out 1; busy out 1.

Function
REQ-009 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-010 req_ready SHALL be 1 in IDLE, and in RESP only while resp_ready=1; 0 otherwise.
REQ-011 On req_valid&req_ready edge: register req_op/a/b/rd into operand registers, next state ISSUE.
REQ-012 rv32zhinx_start SHALL be 1 exactly in ISSUE and WAIT; operation/a/b SHALL be driven from operand registers and remain stable until leaving WAIT.
REQ-013 ISSUE/WAIT: if rv32zhinx_done=1 at the edge, capture rv32zhinx_out into resp_data, resp_rd from tag, resp_err=0, next RESP; else next WAIT.
REQ-014 Latency: accept at edge N, start high cycle N+1, resp_valid high cycle N+2 when done is combinationally 1.
REQ-015 RESP: resp_valid=1; resp_data/resp_rd/resp_err held stable until resp_ready=1.
REQ-016 RESP with resp_ready=1 and req_valid=0: next IDLE; with req_valid=1: accept new request same edge, next ISSUE (back-to-back, one op per 2 cycles).
REQ-017 busy SHALL be 1 in any state other than IDLE.
REQ-018 rv32zhinx_done while not in ISSUE/WAIT SHALL be ignored.
REQ-019 resp_data SHALL be passed unmodified (zero-extended half or compare bit as produced by FPU).

Reset
REQ-020 On nRST low, state SHALL become IDLE immediately; any in-flight op discarded, no response produced.
REQ-021 Reset values: rv32zhinx_start=0, resp_valid=0, resp_err=0, busy=0, req_ready=1 after reset release, operand/result registers=0, resp_rd=0, operation=FPU_HALF_ADD.

Configuration
REQ-022 Macro RV32ZHINX_ISSUE_TIMEOUT_EN defined: a counter SHALL clear on entering ISSUE, increment each WAIT cycle; on reaching TIMEOUT_CYCLES without done, deassert start, set resp_data=0, resp_err=1, next RESP.
REQ-023 Macro undefined: no counter; WAIT persists until done; resp_err SHALL be constant 0.

Verification
REQ-024 FPU_HALF_ADD a=0x3C00 b=0x3C00, done=1 combinational -> resp_valid at cycle N+2, resp_data=0x00004000, resp_err=0.
REQ-025 FPU_HALF_FLT a=0x3C00 b=0x4000, rd=7, resp_ready held 0 for 3 cycles -> resp_valid held, resp_data=0x00000001, resp_rd=7 stable throughout.
REQ-026 Model done delayed 3 cycles -> start high 4 cycles, operands unchanged during wait, resp_valid the cycle after done.
REQ-027 Two requests back-to-back with resp_ready=1 -> second accepted on first response edge, two responses in order, no lost cycle beyond REQ-016.
REQ-028 nRST asserted during WAIT -> start=0, busy=0 immediately; no resp_valid after release.
REQ-029 With RV32ZHINX_ISSUE_TIMEOUT_EN, TIMEOUT_CYCLES=16, done never asserted -> resp_valid with resp_err=1, resp_data=0 after 16 WAIT cycles; without macro -> still waiting at cycle 100.

Source files
------------

// File: rtl/rv32zhinx_issue.sv
// Issue/response controller between an RV32 core and a half-precision (Zhinx) FPU.
// Optional WAIT-state abort: define RV32ZHINX_ISSUE_TIMEOUT_EN to enable the TIMEOUT_CYCLES watchdog.
package rv32zhinx_issue_pkg;
    localparam int WORD_W = 32;

    typedef enum logic [3:0] {
        FPU_HALF_ADD  = 4'd0,
        FPU_HALF_SUB  = 4'd1,
        FPU_HALF_MUL  = 4'd2,
        FPU_HALF_DIV  = 4'd3,
        FPU_HALF_SQRT = 4'd4,
        FPU_HALF_MIN  = 4'd5,
        FPU_HALF_MAX  = 4'd6,
        FPU_HALF_FEQ  = 4'd7,
        FPU_HALF_FLT  = 4'd8,
        FPU_HALF_FLE  = 4'd9
    } fpu_operation_t;
endpackage

module rv32zhinx_issue_ctrl
    import rv32zhinx_issue_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                req_valid,
    output logic                req_ready,
    input  fpu_operation_t      req_op,
    input  logic [WORD_W-1:0]   req_a,
    input  logic [WORD_W-1:0]   req_b,
    input  logic [4:0]          req_rd,
    output logic                rv32zhinx_start,
    output fpu_operation_t      operation,
    output logic [WORD_W-1:0]   rv32zhinx_a,
    output logic [WORD_W-1:0]   rv32zhinx_b,
    input  logic                rv32zhinx_done,
    input  logic [WORD_W-1:0]   rv32zhinx_out,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [WORD_W-1:0]   resp_data,
    output logic [4:0]          resp_rd,
    output logic                resp_err,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    fpu_operation_t      op_r;
    logic [WORD_W-1:0]   a_r;
    logic [WORD_W-1:0]   b_r;
    logic [4:0]          rd_r;
    logic [WORD_W-1:0]   resp_data_r;
    logic [4:0]          resp_rd_r;
    logic                accept_s;
    logic                in_flight_s;
    logic                capture_s;
    logic                timeout_s;

    assign accept_s    = req_valid && req_ready;
    assign in_flight_s = (state_r == ST_ISSUE) || (state_r == ST_WAIT);
    assign capture_s   = in_flight_s && rv32zhinx_done;

`ifdef RV32ZHINX_ISSUE_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt_r;
    logic             resp_err_r;

    // WAIT-cycle counter, restarted for every accepted request
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_WAIT) begin
            wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign timeout_s = (state_r == ST_WAIT) && !rv32zhinx_done && (wait_cnt_r == CNT_LAST);

    // Error flag: set by an abort, cleared by a genuine FPU completion
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            resp_err_r <= 1'b0;
        end else if (capture_s) begin
            resp_err_r <= 1'b0;
        end else if (timeout_s) begin
            resp_err_r <= 1'b1;
        end
    end

    assign resp_err = resp_err_r;
`else
    assign timeout_s = 1'b0;
    assign resp_err  = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) state_nxt_s = ST_ISSUE;
                else           state_nxt_s = ST_IDLE;
            end
            ST_ISSUE, ST_WAIT: begin
                if (rv32zhinx_done || timeout_s) state_nxt_s = ST_RESP;
                else                             state_nxt_s = ST_WAIT;
            end
            ST_RESP: begin
                if (resp_ready) state_nxt_s = req_valid ? ST_ISSUE : ST_IDLE;
                else            state_nxt_s = ST_RESP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State-decoded handshake outputs; RESP accepts a new request in the same edge as the response
    always_comb begin
        req_ready       = 1'b0;
        rv32zhinx_start = 1'b0;
        resp_valid      = 1'b0;
        busy            = 1'b1;
        case (state_r)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_ISSUE, ST_WAIT: begin
                rv32zhinx_start = 1'b1;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                req_ready  = resp_ready;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Operand and result registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            op_r        <= FPU_HALF_ADD;
            a_r         <= {WORD_W{1'b0}};
            b_r         <= {WORD_W{1'b0}};
            rd_r        <= 5'd0;
            resp_data_r <= {WORD_W{1'b0}};
            resp_rd_r   <= 5'd0;
        end else begin
            if (accept_s) begin
                op_r <= req_op;
                a_r  <= req_a;
                b_r  <= req_b;
                rd_r <= req_rd;
            end
            if (capture_s) begin
                resp_data_r <= rv32zhinx_out;
                resp_rd_r   <= rd_r;
            end else if (timeout_s) begin
                resp_data_r <= {WORD_W{1'b0}};
                resp_rd_r   <= rd_r;
            end
        end
    end

    assign operation   = op_r;
    assign rv32zhinx_a = a_r;
    assign rv32zhinx_b = b_r;
    assign resp_data   = resp_data_r;
    assign resp_rd     = resp_rd_r;

endmodule

// File: tb/tb_rv32zhinx_issue_ctrl.sv
// Self-checking bench for rv32zhinx_issue_ctrl: directed vector table, hand sequences,
// and randomized traffic against a transaction-level scoreboard with a mock FPU.
module tb_rv32zhinx_issue_ctrl;
    import rv32zhinx_issue_pkg::*;

    localparam int TO_CYC = 16;

    logic           CLK = 1'b0;
    logic           nRST;
    logic           req_valid, req_ready;
    fpu_operation_t req_op, operation;
    logic [31:0]    req_a, req_b, rv32zhinx_a, rv32zhinx_b, rv32zhinx_out, resp_data;
    logic [4:0]     req_rd, resp_rd;
    logic           rv32zhinx_start, rv32zhinx_done;
    logic           resp_valid, resp_ready, resp_err, busy;

    rv32zhinx_issue_ctrl #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
        .rv32zhinx_start(rv32zhinx_start), .operation(operation),
        .rv32zhinx_a(rv32zhinx_a), .rv32zhinx_b(rv32zhinx_b),
        .rv32zhinx_done(rv32zhinx_done), .rv32zhinx_out(rv32zhinx_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_rd(resp_rd), .resp_err(resp_err), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Mock FPU: done after fpu_delay start cycles, or never; force_done injects stray completions
    logic force_done = 1'b0;
    logic fpu_never  = 1'b0;
    int   fpu_delay  = 0;
    int   fpu_cnt    = 0;

    function automatic logic [31:0] fpu_model(input fpu_operation_t op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            FPU_HALF_ADD: r = (a == 32'h3C00 && b == 32'h3C00) ? 32'h0000_4000 : {16'h0, a[15:0] ^ b[15:0]};
            FPU_HALF_FLT: r = {31'h0, (a[15:0] < b[15:0])};
            default:      r = {16'h0, a[15:0] + b[15:0]} ^ {28'h0, op};
        endcase
        return r;
    endfunction

    assign rv32zhinx_done = force_done | (rv32zhinx_start & ~fpu_never & (fpu_cnt >= fpu_delay));
    assign rv32zhinx_out  = force_done ? 32'hDEAD_BEEF : fpu_model(operation, rv32zhinx_a, rv32zhinx_b);

    always @(posedge CLK) fpu_cnt <= (!rv32zhinx_start || rv32zhinx_done) ? 0 : fpu_cnt + 1;

    typedef struct {
        fpu_operation_t op;
        logic [31:0]    a, b;
        logic [4:0]     rd;
        int             delay;
        int             hold;
        logic [31:0]    exp_data;
    } vec_t;

    vec_t vecs[4];

    task automatic run_vec(input vec_t v, input int idx);
        int cyc, starts;
        bit seen;
        @(negedge CLK);
        fpu_delay = v.delay; resp_ready = 1'b0;
        req_valid = 1'b1; req_op = v.op; req_a = v.a; req_b = v.b; req_rd = v.rd;
        #1 chk($sformatf("v%0d_req_ready", idx), 32'(req_ready), 32'd1);
        @(posedge CLK);
        #1 req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_rd = 5'($urandom);
        cyc = 0; starts = 0; seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(negedge CLK);
            cyc++;
            if (resp_valid) begin
                seen = 1'b1;
            end else begin
                if (rv32zhinx_start) starts++;
                chk($sformatf("v%0d_op_stable", idx), 32'(operation), 32'(v.op));
                chk($sformatf("v%0d_a_stable", idx), rv32zhinx_a, v.a);
                chk($sformatf("v%0d_b_stable", idx), rv32zhinx_b, v.b);
            end
        end
        chk($sformatf("v%0d_latency", idx), 32'(cyc), 32'(v.delay + 2));
        chk($sformatf("v%0d_start_cycles", idx), 32'(starts), 32'(v.delay + 1));
        chk($sformatf("v%0d_start_in_resp", idx), 32'(rv32zhinx_start), 32'd0);
        chk($sformatf("v%0d_data", idx), resp_data, v.exp_data);
        chk($sformatf("v%0d_rd", idx), 32'(resp_rd), 32'(v.rd));
        chk($sformatf("v%0d_err", idx), 32'(resp_err), 32'd0);
        force_done = 1'b1;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge CLK);
            chk($sformatf("v%0d_hold_valid", idx), 32'(resp_valid), 32'd1);
            chk($sformatf("v%0d_hold_data", idx), resp_data, v.exp_data);
            chk($sformatf("v%0d_hold_rd", idx), 32'(resp_rd), 32'(v.rd));
        end
        force_done = 1'b0;
        resp_ready = 1'b1;
        @(negedge CLK);
        chk($sformatf("v%0d_released", idx), 32'(resp_valid), 32'd0);
        chk($sformatf("v%0d_idle_busy", idx), 32'(busy), 32'd0);
        resp_ready = 1'b0;
    endtask

    // Randomized traffic: scoreboard of outstanding responses and predicted valid cycle
    typedef struct { logic [31:0] data; logic [4:0] rd; } exp_t;
    exp_t exp_q[$];
    bit   pend = 1'b0;
    int   outstanding = 0;
    int   valid_from  = 0;

    task automatic rnd_cycle(input bit allow_new, input int c);
        bit exp_valid;
        exp_t e;
        @(negedge CLK);
        if (allow_new && !pend && $urandom_range(0, 2) != 0) begin
            pend   = 1'b1;
            req_op = fpu_operation_t'(4'($urandom_range(0, 9)));
            req_a  = $urandom; req_b = $urandom; req_rd = 5'($urandom);
        end
        req_valid  = allow_new ? pend : 1'b0;
        resp_ready = allow_new ? ($urandom_range(0, 3) != 0) : 1'b1;
        #1;
        exp_valid = (outstanding != 0) && (c >= valid_from);
        chk("rnd_busy", 32'(busy), 32'(outstanding != 0));
        chk("rnd_resp_valid", 32'(resp_valid), 32'(exp_valid));
        chk("rnd_req_ready", 32'(req_ready), 32'((outstanding == 0) || (exp_valid && resp_ready)));
        if (exp_valid && resp_ready) begin
            e = exp_q.pop_front();
            chk("rnd_data", resp_data, e.data);
            chk("rnd_rd", 32'(resp_rd), 32'(e.rd));
            chk("rnd_err", 32'(resp_err), 32'd0);
            outstanding--;
        end
        if (req_valid && ((outstanding == 0) || (exp_valid && resp_ready))) begin
            exp_q.push_back('{fpu_model(req_op, req_a, req_b), req_rd});
            outstanding++;
            pend       = 1'b0;
            fpu_delay  = $urandom_range(0, 3);
            valid_from = c + fpu_delay + 2;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        vecs[0] = '{FPU_HALF_ADD, 32'h3C00, 32'h3C00, 5'd1,  0, 0, 32'h0000_4000};
        vecs[1] = '{FPU_HALF_FLT, 32'h3C00, 32'h4000, 5'd7,  0, 3, 32'h0000_0001};
        vecs[2] = '{FPU_HALF_FLT, 32'h4000, 32'h3C00, 5'd3,  3, 1, 32'h0000_0000};
        vecs[3] = '{FPU_HALF_FLT, 32'h0001, 32'h0002, 5'd31, 1, 2, 32'h0000_0001};

        nRST = 1'b0; req_valid = 1'b0; req_op = FPU_HALF_MUL; req_a = 32'h0; req_b = 32'h0;
        req_rd = 5'd0; resp_ready = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK) nRST = 1'b1;
        @(negedge CLK);
        chk("rst_start", 32'(rv32zhinx_start), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_data", resp_data, 32'h0);
        chk("rst_resp_rd", 32'(resp_rd), 32'd0);
        chk("rst_operation", 32'(operation), 32'(FPU_HALF_ADD));
        chk("rst_a", rv32zhinx_a, 32'h0);
        chk("rst_b", rv32zhinx_b, 32'h0);

        for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

        // Stray done outside ISSUE/WAIT must not produce a response
        force_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("stray_done_valid", 32'(resp_valid), 32'd0);
            chk("stray_done_busy", 32'(busy), 32'd0);
        end
        force_done = 1'b0;

        // Back-to-back requests with resp_ready held high
        @(negedge CLK);
        fpu_delay = 0; resp_ready = 1'b1;
        req_valid = 1'b1; req_op = FPU_HALF_FLT; req_a = 32'h5; req_b = 32'h9; req_rd = 5'd4;
        @(posedge CLK);
        #1 req_op = FPU_HALF_ADD; req_a = 32'h3C00; req_b = 32'h3C00; req_rd = 5'd9;
        @(negedge CLK);
        chk("b2b_issue_ready", 32'(req_ready), 32'd0);
        chk("b2b_issue_start", 32'(rv32zhinx_start), 32'd1);
        @(negedge CLK);
        chk("b2b_r1_valid", 32'(resp_valid), 32'd1);
        chk("b2b_r1_data", resp_data, fpu_model(FPU_HALF_FLT, 32'h5, 32'h9));
        chk("b2b_r1_rd", 32'(resp_rd), 32'd4);
        chk("b2b_r1_ready", 32'(req_ready), 32'd1);
        @(negedge CLK);
        chk("b2b_r2_issue_valid", 32'(resp_valid), 32'd0);
        chk("b2b_r2_start", 32'(rv32zhinx_start), 32'd1);
        chk("b2b_r2_a", rv32zhinx_a, 32'h3C00);
        req_valid = 1'b0;
        @(negedge CLK);
        chk("b2b_r2_valid", 32'(resp_valid), 32'd1);
        chk("b2b_r2_data", resp_data, 32'h0000_4000);
        chk("b2b_r2_rd", 32'(resp_rd), 32'd9);
        @(negedge CLK);
        chk("b2b_idle", 32'(busy), 32'd0);
        resp_ready = 1'b0;

        // Randomized traffic, then drain
        for (int c = 0; c < 400; c++) rnd_cycle(1'b1, c);
        for (int c = 400; c < 430; c++) rnd_cycle(1'b0, c);
        chk("rnd_drained", 32'(outstanding), 32'd0);
        resp_ready = 1'b0;

        // Reset while waiting on the FPU
        @(negedge CLK);
        fpu_never = 1'b1;
        req_valid = 1'b1; req_op = FPU_HALF_DIV; req_a = 32'h1111; req_b = 32'h2222; req_rd = 5'd5;
        @(negedge CLK) req_valid = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rstw_pre_start", 32'(rv32zhinx_start), 32'd1);
        #2 nRST = 1'b0;
        #1;
        chk("rstw_start", 32'(rv32zhinx_start), 32'd0);
        chk("rstw_busy", 32'(busy), 32'd0);
        chk("rstw_valid", 32'(resp_valid), 32'd0);
        @(negedge CLK) nRST = 1'b1;
        fpu_never = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("rstw_after_valid", 32'(resp_valid), 32'd0);
            chk("rstw_after_busy", 32'(busy), 32'd0);
        end

        // FPU that never answers
        @(negedge CLK);
        fpu_never = 1'b1; resp_ready = 1'b0;
        req_valid = 1'b1; req_op = FPU_HALF_SQRT; req_a = 32'h4400; req_b = 32'h0; req_rd = 5'd12;
        @(negedge CLK) req_valid = 1'b0;
        cyc = 1;
        while (!resp_valid && cyc < 100) begin
            @(negedge CLK);
            cyc++;
        end
`ifdef RV32ZHINX_ISSUE_TIMEOUT_EN
        chk("to_latency", 32'(cyc), 32'(TO_CYC + 2));
        chk("to_valid", 32'(resp_valid), 32'd1);
        chk("to_err", 32'(resp_err), 32'd1);
        chk("to_data", resp_data, 32'h0);
        chk("to_rd", 32'(resp_rd), 32'd12);
        chk("to_start", 32'(rv32zhinx_start), 32'd0);
        resp_ready = 1'b1;
        @(negedge CLK);
        chk("to_idle", 32'(busy), 32'd0);
        resp_ready = 1'b0;
`else
        chk("nto_no_valid", 32'(resp_valid), 32'd0);
        chk("nto_start", 32'(rv32zhinx_start), 32'd1);
        chk("nto_busy", 32'(busy), 32'd1);
        chk("nto_err", 32'(resp_err), 32'd0);
        nRST = 1'b0;
        @(negedge CLK) nRST = 1'b1;
`endif
        fpu_never = 1'b0;
        @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
